vin_capture: RTL and testbench

Receive side of the parallel video bus that `vin_internal` drives (`v_vsync`, `v_hsync`, `v_pclk`, `v_de`, `v_pixel`). The block oversamples the bus in the system clock domain, detects `v_pclk` rising edges, and emits a ready/valid pixel stream with start-of-frame and start-of-line tags. The stream is buffered through a small FIFO for the downstream frame writer. Optional logic measures the active width and height of the incoming frames.

---
 rtl/vin_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_vin_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_capture.sv
// rtl/vin_capture.sv - parallel video bus receiver: oversampled capture, sof/sol tagging, output FIFO
// Optional measurement logic is built when VIN_CAPTURE_MEASURE_EN is defined.
module vin_capture #(
    parameter int PIX_W      = 8,
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_vsync,
    input  logic             v_hsync,
    input  logic             v_pclk,
    input  logic             v_de,
    input  logic [PIX_W-1:0] v_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_sol,
    output logic             overflow,
    output logic [CNT_W-1:0] meas_h,
    output logic [CNT_W-1:0] meas_v,
    output logic             err_hlen
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PIX_W + 2;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    logic             s1_vsync, s1_hsync, s1_pclk, s1_de;
    logic [PIX_W-1:0] s1_pixel;
    logic             s2_vsync, s2_hsync, s2_pclk, s2_de;
    logic [PIX_W-1:0] s2_pixel;
    logic             s2_unused;

    logic             ev;
    logic             vs_rise;
    logic             prev_vsync, prev_de;

    state_t           state, state_nxt;
    logic             wr_req, wr_sof, wr_sol;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, rd, wr_ok;
    logic [EW-1:0]    head;

    // Two-stage capture of the video bus into the system clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_pclk  <= 1'b0;
            s1_de    <= 1'b0;
            s1_pixel <= '0;
            s2_vsync <= 1'b0;
            s2_hsync <= 1'b0;
            s2_pclk  <= 1'b0;
            s2_de    <= 1'b0;
            s2_pixel <= '0;
        end else begin
            s1_vsync <= v_vsync;
            s1_hsync <= v_hsync;
            s1_pclk  <= v_pclk;
            s1_de    <= v_de;
            s1_pixel <= v_pixel;
            s2_vsync <= s1_vsync;
            s2_hsync <= s1_hsync;
            s2_pclk  <= s1_pclk;
            s2_de    <= s1_de;
            s2_pixel <= s1_pixel;
        end
    end

    // Only the second-stage pclk feeds the edge detector; the rest of s2 is kept for bus symmetry
    assign s2_unused = ^{s2_vsync, s2_hsync, s2_de, s2_pixel};

    assign ev      = s1_pclk & ~s2_pclk;
    assign vs_rise = ev & s1_vsync & ~prev_vsync;

    // Remember vsync/de as seen at the previous pclk event
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vsync <= 1'b0;
            prev_de    <= 1'b0;
        end else if (ev) begin
            prev_vsync <= s1_vsync;
            prev_de    <= s1_de;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame tracking and FIFO write request; a vsync rising edge always wins over a pixel
    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        wr_sof    = 1'b0;
        wr_sol    = 1'b0;
        case (state)
            WAIT_VS: begin
                if (ev && s1_vsync) begin
                    state_nxt = VBLANK;
                end
            end
            VBLANK: begin
                if (vs_rise) begin
                    state_nxt = VBLANK;
                end else if (ev && s1_de) begin
                    state_nxt = ACTIVE;
                    wr_req    = 1'b1;
                    wr_sof    = 1'b1;
                    wr_sol    = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_nxt = VBLANK;
                end else if (ev && s1_de) begin
                    wr_req = 1'b1;
                    wr_sol = ~prev_de;
                end
            end
            default: begin
                state_nxt = WAIT_VS;
            end
        endcase
    end

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign rd        = out_valid & out_ready;
    assign wr_ok     = wr_req & (~full | rd);

    // FIFO storage; contents need no reset because outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {s1_pixel, wr_sof, wr_sol};
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (wr_req && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pixel = out_valid ? head[EW-1:2] : '0;
    assign out_sof   = out_valid & head[1];
    assign out_sol   = out_valid & head[0];

`ifdef VIN_CAPTURE_MEASURE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] h_cnt, line_cnt, ref_h;

    // Active size measurement; the first line of a frame sets the reference width
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            line_cnt <= '0;
            ref_h    <= '0;
            meas_h   <= '0;
            meas_v   <= '0;
            err_hlen <= 1'b0;
        end else if (vs_rise) begin
            meas_h   <= ref_h;
            meas_v   <= line_cnt;
            line_cnt <= '0;
            h_cnt    <= '0;
        end else if (ev) begin
            if (prev_de && !s1_de) begin
                if (line_cnt != CNT_MAX) begin
                    line_cnt <= line_cnt + CNT_W'(1);
                end
                if (line_cnt == '0) begin
                    ref_h <= h_cnt;
                end else if (h_cnt != ref_h) begin
                    err_hlen <= 1'b1;
                end
                h_cnt <= '0;
            end else if (s1_de && h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign meas_h   = '0;
    assign meas_v   = '0;
    assign err_hlen = 1'b0;
`endif

endmodule

// File: tb/tb_vin_capture.sv
// tb/tb_vin_capture.sv - self-checking bench for vin_capture with stream scoreboard
module tb_vin_capture;

`ifdef VIN_CAPTURE_MEASURE_EN
    localparam int MEAS = 1;
`else
    localparam int MEAS = 0;
`endif

    logic        clk;
    logic        rst;
    logic        v_vsync, v_hsync, v_pclk, v_de;
    logic [7:0]  v_pixel;
    logic        out_valid, out_ready;
    logic [7:0]  out_pixel;
    logic        out_sof, out_sol, overflow;
    logic [11:0] meas_h, meas_v;
    logic        err_hlen;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       vs;
        logic       de;
        logic [7:0] pix;
        logic       ex;
        logic       sof;
        logic       sol;
    } vec_t;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       sol;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;

    vin_capture #(.PIX_W(8), .CNT_W(12), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .v_vsync   (v_vsync),
        .v_hsync   (v_hsync),
        .v_pclk    (v_pclk),
        .v_de      (v_de),
        .v_pixel   (v_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_sof   (out_sof),
        .out_sol   (out_sol),
        .overflow  (overflow),
        .meas_h    (meas_h),
        .meas_v    (meas_v),
        .err_hlen  (err_hlen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // Stream scoreboard: every handshake must match the oldest expected pixel
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL stream: got pixel %0h sof %0b sol %0b, expected no output",
                         out_pixel, out_sof, out_sol);
            end else begin
                e = sb.pop_front();
                if ({out_pixel, out_sof, out_sol} !== {e.pix, e.sof, e.sol}) begin
                    n_fail++;
                    $display("FAIL stream: got pixel %0h sof %0b sol %0b, expected pixel %0h sof %0b sol %0b",
                             out_pixel, out_sof, out_sol, e.pix, e.sof, e.sol);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_ev(input logic vs, input logic de, input logic [7:0] pix,
                          input logic ex, input logic sof, input logic sol);
        vec_t v;
        v.vs = vs; v.de = de; v.pix = pix; v.ex = ex; v.sof = sof; v.sol = sol;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_ev(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vsync();
        add_ev(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_ev(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_idle(1);
    endtask

    task automatic add_pixels(input int n, input logic [7:0] base, input logic first_of_frame,
                              input logic line_start);
        for (int i = 0; i < n; i++)
            add_ev(1'b0, 1'b1, base + 8'(i), 1'b1, first_of_frame && (i == 0), line_start && (i == 0));
    endtask

    task automatic add_line(input int n, input logic [7:0] base, input logic first_of_frame);
        add_pixels(n, base, first_of_frame, 1'b1);
        add_idle(2);
    endtask

    // One pclk period = two clk periods; data is set up while pclk is low
    task automatic pix(input logic vs, input logic de, input logic [7:0] p);
        @(posedge clk); #1;
        v_pclk  = 1'b0;
        v_vsync = vs;
        v_de    = de;
        v_hsync = ~de;
        v_pixel = p;
        @(posedge clk); #1;
        v_pclk  = 1'b1;
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].ex) sb.push_back('{vecs[i].pix, vecs[i].sof, vecs[i].sol});
            pix(vecs[i].vs, vecs[i].de, vecs[i].pix);
        end
        vecs.delete();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, " pending"}, sb.size(), 0);
        check({name, " out_valid"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        rst = 1'b1;
        v_vsync = 1'b0; v_hsync = 1'b0; v_pclk = 1'b0; v_de = 1'b0; v_pixel = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 0);
        check("reset out_pixel", {24'd0, out_pixel}, 0);
        check("reset out_sof",   {31'd0, out_sof}, 0);
        check("reset out_sol",   {31'd0, out_sol}, 0);
        check("reset overflow",  {31'd0, overflow}, 0);
        check("reset meas_h",    {20'd0, meas_h}, 0);
        check("reset meas_v",    {20'd0, meas_v}, 0);
        check("reset err_hlen",  {31'd0, err_hlen}, 0);
        rst = 1'b0;

        // Pixels before any vsync are discarded
        for (int i = 0; i < 10; i++) add_ev(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        add_idle(1);
        run_vecs();
        repeat (4) @(posedge clk);
        #1;
        check("no_vs out_valid", {31'd0, out_valid}, 0);
        check("no_vs overflow",  {31'd0, overflow}, 0);

        // Normal frame: 3 lines of 4
        add_vsync();
        add_line(4, 8'h10, 1'b1);
        add_line(4, 8'h14, 1'b0);
        add_line(4, 8'h18, 1'b0);
        add_vsync();
        run_vecs();
        wait_drain("frame1");
        check("frame1 meas_h",   {20'd0, meas_h}, 32'(MEAS * 4));
        check("frame1 meas_v",   {20'd0, meas_v}, 32'(MEAS * 3));
        check("frame1 err_hlen", {31'd0, err_hlen}, 0);

        // Short third line
        add_line(4, 8'h20, 1'b1);
        add_line(4, 8'h24, 1'b0);
        add_line(3, 8'h28, 1'b0);
        run_vecs();
        check("short err_hlen", {31'd0, err_hlen}, 32'(MEAS));
        add_vsync();
        add_line(4, 8'h30, 1'b1);
        add_line(4, 8'h34, 1'b0);
        run_vecs();
        check("frame2 meas_h",  {20'd0, meas_h}, 32'(MEAS * 4));
        check("frame2 meas_v",  {20'd0, meas_v}, 32'(MEAS * 3));
        add_vsync();
        run_vecs();
        wait_drain("frame3");
        check("frame3 err_hlen sticky", {31'd0, err_hlen}, 32'(MEAS));
        check("frame3 meas_v", {20'd0, meas_v}, 32'(MEAS * 2));

        // Full FIFO with a read in the same cycle as the write
        out_ready = 1'b0;
        add_pixels(4, 8'h50, 1'b1, 1'b1);
        run_vecs();
        sb.push_back('{8'h54, 1'b0, 1'b0});
        @(posedge clk); #1;
        v_pclk = 1'b0; v_vsync = 1'b0; v_de = 1'b1; v_hsync = 1'b0; v_pixel = 8'h54;
        @(posedge clk); #1;
        v_pclk = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("concurrent overflow",  {31'd0, overflow}, 0);
        check("concurrent out_valid", {31'd0, out_valid}, 1);
        add_idle(2);
        run_vecs();
        out_ready = 1'b1;
        wait_drain("concurrent");
        check("concurrent overflow after drain", {31'd0, overflow}, 0);

        // Backpressure: 6 pixels into a 4-entry FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            add_ev(1'b0, 1'b1, 8'h40 + 8'(i), (i < 4), 1'b0, (i == 0));
        add_idle(2);
        run_vecs();
        check("backpressure overflow",  {31'd0, overflow}, 1);
        check("backpressure out_valid", {31'd0, out_valid}, 1);
        out_ready = 1'b1;
        wait_drain("backpressure");

        // Reset in the middle of line 2
        add_vsync();
        add_line(4, 8'h60, 1'b1);
        run_vecs();
        wait_drain("pre_reset");
        pix(1'b0, 1'b1, 8'h64);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset out_valid", {31'd0, out_valid}, 0);
        check("midreset overflow",  {31'd0, overflow}, 0);
        check("midreset err_hlen",  {31'd0, err_hlen}, 0);
        check("midreset meas_h",    {20'd0, meas_h}, 0);
        check("midreset meas_v",    {20'd0, meas_v}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) add_ev(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        add_idle(2);
        add_vsync();
        add_line(2, 8'h70, 1'b1);
        add_vsync();
        run_vecs();
        wait_drain("post_reset");
        check("post_reset meas_h", {20'd0, meas_h}, 32'(MEAS * 2));
        check("post_reset meas_v", {20'd0, meas_v}, 32'(MEAS * 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
